// File: rtl/sar_search_4bit.sv
// MSB-first successive-approximation search driving an external comparator's b input.
// Latency k cycles on early equality at probe k, else WIDTH+1; start is taken only when idle.
module sar_search_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             agb,
  input  logic             aeb,
  input  logic             alb,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB     = ONE << (WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_VERIFY} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_i;
  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_found;
  logic             r_err;

  logic             w_onehot;
  logic [WIDTH-1:0] w_bit_i;
  logic [WIDTH-1:0] w_kept;
  logic [WIDTH-1:0] w_next_probe;

  assign w_onehot = (agb & ~aeb & ~alb) | (~agb & aeb & ~alb) | (~agb & ~aeb & alb);
  assign w_bit_i  = ONE << r_i;
  // Keep the probed bit when target is above trial, drop it when below.
  assign w_kept       = agb ? r_trial : (r_trial & ~w_bit_i);
  assign w_next_probe = w_kept | (w_bit_i >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_i      <= IDX_TOP;
      r_trial  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_i      <= IDX_TOP;
            r_trial  <= MSB;
            r_busy   <= 1'b1;
            r_state  <= S_PROBE;
          end
        end
        S_PROBE: begin
          if (!w_onehot) begin
            r_err    <= 1'b1;
            r_found  <= 1'b0;
            r_result <= r_trial;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (aeb) begin
            r_found  <= 1'b1;
            r_result <= r_trial;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_i != '0) begin
            r_trial <= w_next_probe;
            r_i     <= r_i - IW'(1);
          end else begin
            r_result <= w_kept;
            r_trial  <= w_kept;
            r_state  <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          // A clean agb/alb here means an inconsistent comparator: not found, but no err.
          if (!w_onehot) begin
            r_err    <= 1'b1;
            r_found  <= 1'b0;
            r_result <= r_trial;
          end else begin
            r_found <= aeb;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign trial  = r_trial;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign found  = r_found;
  assign err    = r_err;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Bench for sar_search_4bit: comparator model a=target, b=trial, with flag fault injection.
module tb_sar_search_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       agb, aeb, alb;
  logic [3:0] trial, result;
  logic       busy, done, found, err;

  logic [3:0] target = 4'd0;
  logic       flt_en = 1'b0;
  logic [2:0] flt_val = 3'b000;

  int checks = 0;
  int failures = 0;

  logic [3:0] obs_seq[$];
  int         obs_lat;
  logic [3:0] obs_res;
  logic       obs_found, obs_err, obs_busy, obs_tout;

  always #5 clk = ~clk;

  assign {agb, aeb, alb} = flt_en ? flt_val
                                  : {target > trial, target == trial, target < trial};

  sar_search_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .agb(agb), .aeb(aeb), .alb(alb),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .found(found), .err(err)
  );

  // Probe k of a clean binary search: target's top k-1 bits with the next bit set.
  function automatic logic [3:0] exp_trial(input logic [3:0] tgt, input int k);
    int t;
    int s;
    t = int'(tgt);
    if (k > 4) return tgt;
    s = 5 - k;
    return 4'(((t >> s) << s) | (1 << (4 - k)));
  endfunction

  function automatic int exp_lat(input logic [3:0] tgt);
    for (int k = 1; k <= 4; k++)
      if (exp_trial(tgt, k) == tgt) return k;
    return 5;
  endfunction

  // Pulses start, records the trial of every probe cycle and captures the done cycle.
  task automatic run_search(input logic [3:0] tgt, input int flt_probe,
                            input logic [2:0] fv, input int start_poke);
    target = tgt;
    flt_val = fv;
    obs_seq.delete();
    obs_tout = 1'b0;
    obs_lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      if (n == 20) begin
        obs_tout = 1'b1;
        break;
      end
      if (done) begin
        obs_lat = n;
        obs_res = result;
        obs_found = found;
        obs_err = err;
        obs_busy = busy;
        break;
      end
      if (busy) obs_seq.push_back(trial);
      flt_en = (obs_seq.size() == flt_probe);
      start = (n == start_poke);
      @(negedge clk);
    end
    flt_en = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({trial, result, busy, done, found, err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got trial=%h result=%h busy=%b done=%b found=%b err=%b want all 0",
               trial, result, busy, done, found, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed(input logic [3:0] tgt);
    int lat;
    lat = exp_lat(tgt);
    run_search(tgt, 0, 3'b000, -1);
    checks++;
    if (obs_tout) begin
      failures++;
      $display("FAIL dir_timeout target=%h no done within 20 cycles", tgt);
      return;
    end
    checks++;
    if (obs_lat != lat || obs_seq.size() != lat) begin
      failures++;
      $display("FAIL dir_latency target=%h got lat=%0d probes=%0d want %0d", tgt, obs_lat, obs_seq.size(), lat);
    end
    for (int k = 1; k <= obs_seq.size() && k <= lat; k++) begin
      checks++;
      if (obs_seq[k-1] !== exp_trial(tgt, k)) begin
        failures++;
        $display("FAIL dir_trial target=%h probe=%0d got %h want %h", tgt, k, obs_seq[k-1], exp_trial(tgt, k));
      end
    end
    checks++;
    if (obs_res !== tgt || obs_found !== 1'b1 || obs_err !== 1'b0 || obs_busy !== 1'b0) begin
      failures++;
      $display("FAIL dir_outcome target=%h got result=%h found=%b err=%b busy=%b want %h 1 0 0",
               tgt, obs_res, obs_found, obs_err, obs_busy, tgt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== tgt || found !== 1'b1) begin
      failures++;
      $display("FAIL dir_hold target=%h got done=%b result=%h found=%b want 0 %h 1", tgt, done, result, found, tgt);
    end
  endtask

  task automatic test_fault_probe;
    run_search(4'hB, 2, 3'b000, -1);
    checks++;
    if (obs_tout || obs_lat != 2 || obs_res !== 4'hC || obs_found !== 1'b0 || obs_err !== 1'b1) begin
      failures++;
      $display("FAIL fault_probe got tout=%b lat=%0d result=%h found=%b err=%b want 0 2 c 0 1",
               obs_tout, obs_lat, obs_res, obs_found, obs_err);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || result !== 4'hC || done !== 1'b0) begin
      failures++;
      $display("FAIL fault_hold got err=%b result=%h done=%b want 1 c 0", err, result, done);
    end
  endtask

  task automatic test_fault_verify;
    run_search(4'h0, 5, 3'b100, -1);
    checks++;
    if (obs_tout || obs_lat != 5 || obs_res !== 4'h0 || obs_found !== 1'b0 || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL fault_verify got tout=%b lat=%0d result=%h found=%b err=%b want 0 5 0 0 0",
               obs_tout, obs_lat, obs_res, obs_found, obs_err);
    end
  endtask

  task automatic test_start_ignored_and_reset;
    target = 4'hB;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (trial !== 4'h8 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ign_first got trial=%h busy=%b want 8 1", trial, busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (trial !== 4'hC) begin
      failures++;
      $display("FAIL ign_start got trial=%h want c", trial);
    end
    @(negedge clk);
    checks++;
    if (trial !== 4'hA) begin
      failures++;
      $display("FAIL ign_third got trial=%h want a", trial);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({trial, result, busy, done, found, err} !== 12'h000) begin
      failures++;
      $display("FAIL midreset got trial=%h result=%h busy=%b done=%b found=%b err=%b want all 0",
               trial, result, busy, done, found, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL postreset_idle cycle=%0d got done=%b busy=%b want 0 0", n, done, busy);
      end
    end
    test_directed(4'h3);
  endtask

  task automatic test_random;
    logic [3:0] tgt;
    for (int r = 0; r < 24; r++) begin
      tgt = 4'($urandom_range(0, 15));
      run_search(tgt, 0, 3'b000, ($urandom_range(0, 1) == 1) ? 1 : -1);
      checks++;
      if (obs_tout || obs_lat != exp_lat(tgt) || obs_res !== tgt || obs_found !== 1'b1 || obs_err !== 1'b0) begin
        failures++;
        $display("FAIL rand target=%h got tout=%b lat=%0d result=%h found=%b err=%b want lat=%0d result=%h 1 0",
                 tgt, obs_tout, obs_lat, obs_res, obs_found, obs_err, exp_lat(tgt), tgt);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit seen;
    target = 4'h5;
    @(negedge clk);
    start = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen || result !== 4'h5) begin
      failures++;
      $display("FAIL b2b_first got seen=%b result=%h want 1 5", seen, result);
    end
    target = 4'h9;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || trial !== 4'h8 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart got busy=%b trial=%h done=%b want 1 8 0", busy, trial, done);
    end
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen || result !== 4'h9 || found !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got seen=%b result=%h found=%b want 1 9 1", seen, result, found);
    end
  endtask

  initial begin
    test_reset();
    test_directed(4'hB);
    test_directed(4'h0);
    test_directed(4'hF);
    test_fault_probe();
    test_fault_verify();
    test_start_ignored_and_reset();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
